// File: rtl/wrr_arb_pkg.sv
// Shared types for the weighted round-robin FIFO write-port arbiter.
// State encoding and the widest source count the 4-bit index supports.
package wrr_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int MAX_WIDTH = 16;
  localparam int IDX_BITS  = $clog2(MAX_WIDTH);

endpackage

// File: rtl/rr_prio_encoder.sv
// Rotating-priority first-one finder: returns the first set bit of
// eligible at or after start, wrapping past WIDTH-1 back to 0.
module rr_prio_encoder
  import wrr_arb_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0]    eligible,
  input  logic [IDX_BITS-1:0] start,
  output logic [IDX_BITS-1:0] index,
  output logic                found
);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] rot;
  logic [IDX_BITS:0]  sum;

  assign dbl = {eligible, eligible};
  assign rot = dbl >> start;

  // Lowest rotated offset wins; map it back to an absolute index.
  always_comb begin
    found = 1'b0;
    sum   = '0;
    index = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum   = {1'b0, start} + (IDX_BITS + 1)'(k);
        found = 1'b1;
      end
    end
    if (sum >= (IDX_BITS + 1)'(WIDTH))
      index = IDX_BITS'(sum - (IDX_BITS + 1)'(WIDTH));
    else
      index = sum[IDX_BITS-1:0];
  end

endmodule

// File: rtl/wrr_fifo_arbiter.sv
// Weighted round-robin arbiter sharing the SRAM FIFO write port
// between source FIFOs, with hold requests and downstream backpressure.
module wrr_fifo_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int WEIGHT_BITS = 4
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST,
  input  logic [WIDTH-1:0]         ENABLE,
  input  logic [WIDTH*WEIGHT_BITS-1:0] WEIGHT,
  input  logic [WIDTH-1:0]         WRITE_REQ,
  input  logic [WIDTH-1:0]         HOLD_REQ,
  input  logic [WIDTH*32-1:0]      DATA_IN,
  input  logic                     READY_IN,
  output logic [WIDTH-1:0]         READ_GRANT,
  output logic                     WRITE_OUT,
  output logic [31:0]              DATA_OUT,
  output logic [IDX_BITS-1:0]      GRANT_ID,
  output logic                     BUSY
);

  localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(WIDTH - 1);

  state_t                 state;
  logic [IDX_BITS-1:0]    ptr;
  logic [IDX_BITS-1:0]    start;
  logic [IDX_BITS-1:0]    pick;
  logic                   found;
  logic [WEIGHT_BITS-1:0] cnt;
  logic [WIDTH-1:0]       eligible;

  logic                   req_c;
  logic                   hold_c;
  logic                   en_c;
  logic [WEIGHT_BITS-1:0] w_c;
  logic [31:0]            d_c;
  logic [WIDTH-1:0]       onehot;
  logic                   strobe;
  logic                   release_c;

  assign eligible = WRITE_REQ & ENABLE;
  assign start    = (ptr == LAST) ? '0 : ptr + 1'b1;

  rr_prio_encoder #(
    .WIDTH (WIDTH)
  ) u_enc (
    .eligible (eligible),
    .start    (start),
    .index    (pick),
    .found    (found)
  );

  // Pull out the granted source's request, hold, enable, weight, data.
  always_comb begin
    req_c  = 1'b0;
    hold_c = 1'b0;
    en_c   = 1'b0;
    w_c    = '0;
    d_c    = '0;
    onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (GRANT_ID == IDX_BITS'(i)) begin
        req_c     = WRITE_REQ[i];
        hold_c    = HOLD_REQ[i];
        en_c      = ENABLE[i];
        w_c       = WEIGHT[i*WEIGHT_BITS +: WEIGHT_BITS];
        d_c       = DATA_IN[i*32 +: 32];
        onehot[i] = 1'b1;
      end
    end
  end

  assign strobe     = (state == GRANT) & req_c & READY_IN;
  assign READ_GRANT = strobe ? onehot : '0;
  assign BUSY       = (state == GRANT);

  // Burst ends on its last word, or when the source empties or is
  // disabled; an active hold overrides all three.
  assign release_c = ~hold_c &
                     ((strobe & (cnt == w_c)) | ~req_c | ~en_c);

  // Arbitration, burst counting and the registered write side.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state     <= ARB;
      ptr       <= '0;
      cnt       <= '0;
      GRANT_ID  <= '0;
      WRITE_OUT <= 1'b0;
      DATA_OUT  <= '0;
    end else begin
      case (state)
        ARB: begin
          WRITE_OUT <= 1'b0;
          if (found) begin
            GRANT_ID <= pick;
            cnt      <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          WRITE_OUT <= strobe;
          if (strobe) begin
            DATA_OUT <= d_c;
            if (cnt != '1)
              cnt <= cnt + 1'b1;
          end
          if (release_c) begin
            ptr   <= GRANT_ID;
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_fifo_arbiter.sv
// Self-checking bench for wrr_fifo_arbiter: source FIFOs as arrays and
// a burst-level reference model checked every cycle plus per-scenario checks.
module tb_wrr_fifo_arbiter;

  localparam int W  = 6;
  localparam int WB = 4;
  localparam int QD = 256;

  logic          BUS_CLK = 1'b0;
  logic          BUS_RST = 1'b0;
  logic [W-1:0]  ENABLE;
  logic [W*WB-1:0] WEIGHT;
  logic [W-1:0]  WRITE_REQ;
  logic [W-1:0]  HOLD_REQ;
  logic [W*32-1:0] DATA_IN;
  logic          READY_IN;
  logic [W-1:0]  READ_GRANT;
  logic          WRITE_OUT;
  logic [31:0]   DATA_OUT;
  logic [3:0]    GRANT_ID;
  logic          BUSY;

  wrr_fifo_arbiter #(.WIDTH(W), .WEIGHT_BITS(WB)) dut (
    .BUS_CLK    (BUS_CLK),
    .BUS_RST    (BUS_RST),
    .ENABLE     (ENABLE),
    .WEIGHT     (WEIGHT),
    .WRITE_REQ  (WRITE_REQ),
    .HOLD_REQ   (HOLD_REQ),
    .DATA_IN    (DATA_IN),
    .READY_IN   (READY_IN),
    .READ_GRANT (READ_GRANT),
    .WRITE_OUT  (WRITE_OUT),
    .DATA_OUT   (DATA_OUT),
    .GRANT_ID   (GRANT_ID),
    .BUSY       (BUSY)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [W][QD];
  int hd [W];
  int tl [W];
  int seq = 0;

  // reference model: owner -1 means the port is being arbitrated
  int          m_owner;
  int          m_served;
  int          m_ptr;
  logic [3:0]  m_gid;
  logic        m_wo;
  logic [31:0] m_do;
  int          m_cnt [W];

  // DUT observations
  int prev_busy;
  int cur_burst;
  int n_idle;
  int st_cnt [W];
  int glog [$];
  int blog [$];

  function automatic int qn(int s);
    return tl[s] - hd[s];
  endfunction

  task automatic push(int s);
    mem[s][tl[s] % QD] = (s << 24) | (seq & 32'h00ff_ffff);
    seq++;
    tl[s]++;
  endtask

  task automatic drive();
    for (int i = 0; i < W; i++) begin
      WRITE_REQ[i] = qn(i) > 0;
      DATA_IN[i*32 +: 32] = (qn(i) > 0) ? mem[i][hd[i] % QD] : 32'h0;
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_served = 0; m_ptr = 0;
    m_gid = '0; m_wo = 1'b0; m_do = '0;
    prev_busy = 0;
  endtask

  task automatic clear_all();
    for (int i = 0; i < W; i++) begin
      hd[i] = 0; tl[i] = 0; m_cnt[i] = 0; st_cnt[i] = 0;
    end
    ENABLE = '0; WEIGHT = '0; HOLD_REQ = '0; READY_IN = 1'b1;
    glog.delete(); blog.delete(); n_idle = 0; cur_burst = 0;
    drive();
  endtask

  task automatic apply_reset();
    BUS_RST = 1'b1;
    drive();
    repeat (2) @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    model_reset();
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step();
    logic [W-1:0] eg;
    bit st;
    int c, cnt, wc, j;
    bit rel, got;
    drive();
    #1;
    eg = '0; st = 0;
    if (m_owner >= 0 && WRITE_REQ[m_owner] && READY_IN) begin
      st = 1; eg[m_owner] = 1'b1;
    end
    n_cmp++;
    if (READ_GRANT !== eg) begin
      n_bad++;
      $display("FAIL read_grant t=%0t got %b want %b", $time, READ_GRANT, eg);
    end
    n_cmp++;
    if (WRITE_OUT !== m_wo) begin
      n_bad++;
      $display("FAIL write_out t=%0t got %b want %b", $time, WRITE_OUT, m_wo);
    end
    n_cmp++;
    if (DATA_OUT !== m_do) begin
      n_bad++;
      $display("FAIL data_out t=%0t got %h want %h", $time, DATA_OUT, m_do);
    end
    n_cmp++;
    if (BUSY !== (m_owner >= 0)) begin
      n_bad++;
      $display("FAIL busy t=%0t got %b want %b", $time, BUSY, m_owner >= 0);
    end
    n_cmp++;
    if (GRANT_ID !== m_gid) begin
      n_bad++;
      $display("FAIL grant_id t=%0t got %0d want %0d", $time, GRANT_ID, m_gid);
    end
    if (BUSY && !prev_busy) begin
      glog.push_back(int'(GRANT_ID));
      cur_burst = 0;
    end
    if (!BUSY && prev_busy) blog.push_back(cur_burst);
    if (|READ_GRANT) cur_burst++;
    if (BUSY && READ_GRANT == '0) n_idle++;
    for (int i = 0; i < W; i++) if (READ_GRANT[i]) st_cnt[i]++;
    prev_busy = BUSY;
    if (m_owner < 0) begin
      m_wo = 1'b0;
      got = 0;
      for (int k = 1; k <= W; k++) begin
        j = (m_ptr + k) % W;
        if (!got && WRITE_REQ[j] && ENABLE[j]) begin
          got = 1; m_owner = j; m_gid = 4'(j); m_served = 0;
        end
      end
    end else begin
      c = m_owner;
      m_wo = st;
      if (st) begin
        m_do = mem[c][hd[c] % QD];
        hd[c]++;
        m_cnt[c]++;
      end
      cnt = (m_served > 15) ? 15 : m_served;
      wc = int'(WEIGHT[c*WB +: WB]);
      rel = !HOLD_REQ[c] &&
            ((st && cnt == wc) || !WRITE_REQ[c] || !ENABLE[c]);
      if (st) m_served++;
      if (rel) begin
        m_ptr = c; m_owner = -1;
      end
    end
    @(negedge BUS_CLK);
  endtask

  task automatic test_reset();
    clear_all();
    #1 BUS_RST = 1'b1;
    #2;
    n_cmp++;
    if (READ_GRANT !== '0 || WRITE_OUT !== 1'b0 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_strobes got rg=%b wo=%b busy=%b want 0", READ_GRANT, WRITE_OUT, BUSY);
    end
    n_cmp++;
    if (DATA_OUT !== 32'h0 || GRANT_ID !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_regs got do=%h id=%0d want 0", DATA_OUT, GRANT_ID);
    end
    apply_reset();
  endtask

  task automatic test_single_burst();
    clear_all(); apply_reset();
    ENABLE[2] = 1'b1;
    WEIGHT[2*WB +: WB] = 4'd3;
    for (int i = 0; i < 10; i++) push(2);
    for (int i = 0; i < 20; i++) step();
    n_cmp++;
    if (blog.size() != 3) begin
      n_bad++;
      $display("FAIL single_bursts got %0d bursts want 3", blog.size());
    end else begin
      n_cmp++;
      if (blog[0] != 4 || blog[1] != 4 || blog[2] != 2) begin
        n_bad++;
        $display("FAIL single_lens got %0d,%0d,%0d want 4,4,2", blog[0], blog[1], blog[2]);
      end
    end
    n_cmp++;
    if (st_cnt[2] != 10) begin
      n_bad++;
      $display("FAIL single_total got %0d want 10", st_cnt[2]);
    end
  endtask

  task automatic test_rr_weight0();
    int exp_order [6] = '{2, 5, 0, 2, 5, 0};
    clear_all(); apply_reset();
    ENABLE = 6'b100101;
    for (int i = 0; i < 6; i++) begin
      push(0); push(2); push(5);
    end
    for (int i = 0; i < 4; i++) push(1);
    for (int i = 0; i < 13; i++) step();
    n_cmp++;
    if (glog.size() < 6) begin
      n_bad++;
      $display("FAIL rr_count got %0d grants want >=6", glog.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (glog[i] != exp_order[i]) begin
          n_bad++;
          $display("FAIL rr_order[%0d] got %0d want %0d", i, glog[i], exp_order[i]);
        end
      end
    end
    n_cmp++;
    if (st_cnt[1] != 0) begin
      n_bad++;
      $display("FAIL rr_disabled got %0d strobes want 0", st_cnt[1]);
    end
  endtask

  task automatic test_hold();
    int stall = 0;
    int at_first3 = -1;
    clear_all(); apply_reset();
    ENABLE = 6'b001010;
    WEIGHT[1*WB +: WB] = 4'd1;
    HOLD_REQ[1] = 1'b1;
    for (int i = 0; i < 3; i++) push(1);
    for (int i = 0; i < 4; i++) push(3);
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (m_cnt[1] == 3 && qn(1) == 0) begin
        if (stall == 3) begin
          for (int i = 0; i < 3; i++) push(1);
        end else begin
          stall++;
        end
      end
      if (m_cnt[1] >= 6) HOLD_REQ[1] = 1'b0;
      step();
      if (at_first3 < 0 && st_cnt[3] > 0) at_first3 = st_cnt[1];
    end
    n_cmp++;
    if (at_first3 != 6) begin
      n_bad++;
      $display("FAIL hold_contig got %0d src1 words before src3 want 6", at_first3);
    end
    n_cmp++;
    if (n_idle != 4) begin
      n_bad++;
      $display("FAIL hold_stall got %0d idle grant cycles want 4", n_idle);
    end
    n_cmp++;
    if (st_cnt[3] != 4) begin
      n_bad++;
      $display("FAIL hold_src3 got %0d want 4", st_cnt[3]);
    end
  endtask

  task automatic test_backpressure();
    int bp = 0;
    clear_all(); apply_reset();
    ENABLE[0] = 1'b1;
    WEIGHT[0 +: WB] = 4'd7;
    for (int i = 0; i < 16; i++) push(0);
    for (int cyc = 0; cyc < 30; cyc++) begin
      READY_IN = 1'b1;
      if (m_cnt[0] >= 3 && bp < 5) begin
        READY_IN = 1'b0; bp++;
      end
      step();
    end
    n_cmp++;
    if (blog.size() < 1 || blog[0] != 8) begin
      n_bad++;
      $display("FAIL bp_burst got %0d want 8", blog.size() > 0 ? blog[0] : -1);
    end
    n_cmp++;
    if (st_cnt[0] != 16) begin
      n_bad++;
      $display("FAIL bp_total got %0d want 16", st_cnt[0]);
    end
    n_cmp++;
    if (n_idle != 5) begin
      n_bad++;
      $display("FAIL bp_stall got %0d stalled cycles want 5", n_idle);
    end
  endtask

  task automatic test_async_reset();
    clear_all(); apply_reset();
    ENABLE = 6'b101000;
    WEIGHT[3*WB +: WB] = 4'd7;
    WEIGHT[5*WB +: WB] = 4'd7;
    for (int i = 0; i < 10; i++) begin
      push(3); push(5);
    end
    for (int k = 0; k < 40 && m_cnt[5] < 2; k++) step();
    drive();
    #1 BUS_RST = 1'b1;
    #1;
    n_cmp++;
    if (READ_GRANT !== '0 || WRITE_OUT !== 1'b0 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst got rg=%b wo=%b busy=%b want 0", READ_GRANT, WRITE_OUT, BUSY);
    end
    model_reset();
    glog.delete();
    repeat (2) @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (glog.size() < 1 || glog[0] != 3) begin
      n_bad++;
      $display("FAIL async_restart got %0d want 3", glog.size() > 0 ? glog[0] : -1);
    end
  endtask

  task automatic test_enable_drop();
    clear_all(); apply_reset();
    ENABLE = 6'b010001;
    WEIGHT[4*WB +: WB] = 4'd7;
    for (int i = 0; i < 10; i++) push(4);
    for (int i = 0; i < 3; i++) push(0);
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (m_cnt[4] == 2) ENABLE[4] = 1'b0;
      step();
    end
    n_cmp++;
    if (blog.size() < 1 || blog[0] != 3) begin
      n_bad++;
      $display("FAIL en_drop_len got %0d want 3", blog.size() > 0 ? blog[0] : -1);
    end
    n_cmp++;
    if (glog.size() < 2 || glog[1] != 0) begin
      n_bad++;
      $display("FAIL en_drop_next got %0d want 0", glog.size() > 1 ? glog[1] : -1);
    end
  endtask

  task automatic test_random();
    int pushed = 0;
    clear_all(); apply_reset();
    for (int i = 0; i < W; i++)
      WEIGHT[i*WB +: WB] = 4'($urandom_range(0, 15));
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 40 == 0) ENABLE = W'($urandom_range(0, 63)) | W'(1);
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 2) == 0 && qn(i) < 200) begin
          push(i); pushed++;
        end
        HOLD_REQ[i] = ($urandom_range(0, 9) == 0);
      end
      READY_IN = ($urandom_range(0, 4) != 0);
      step();
    end
    n_cmp++;
    if (pushed == 0 || glog.size() == 0) begin
      n_bad++;
      $display("FAIL random_activity got %0d grants want >0", glog.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_rr_weight0();
    test_hold();
    test_backpressure();
    test_async_reset();
    test_enable_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
